// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared defaults for the load-use hazard scoreboard and the helper that
//   sizes its down-counters.
package hazard_scoreboard_pkg;

  localparam int HS_REG_AW    = 3;
  localparam int HS_LOAD_LAT  = 3;
  localparam int HS_ALU_FWD   = 2;
  localparam int HS_BR_FWD    = 0;
  localparam int HS_R0_ZERO   = 1;
  localparam int HS_MAX_STALL = 15;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_counter.sv
// hs_reg_counter
//   One register's "cycles until load data is written back" counter.
//   Loads LOAD_VAL on load (load beats decrement), otherwise counts down
//   to zero and holds there.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the count
//   load   restart the count at LOAD_VAL
//   count  current remaining latency
module hs_reg_counter #(
  parameter int CW       = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_VAL);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = LOAD_CNT;
    end else if (count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use hazard detector for an in-order pipeline. Each architectural
//   register has a counter holding the cycles until an in-flight load's data
//   is written back. An ID instruction stalls when a source it reads is
//   still further away than the forwarding network can cover (branches
//   resolve in ID and therefore need the data earlier than ALU ops).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid                valid instruction in ID
//   id_rs/id_rt             source registers, id_use_rs/id_use_rt read enables
//   id_is_branch            ID instruction resolves a branch in ID
//   id_load, id_dst         ID instruction is a load to id_dst
//   id_flush                ID instruction is being killed (no stall, no issue)
//   stat_clr                clear stall_cycles
//   ctrl_flush              bubble into EX (= stall)
//   PCwrite, Id_write       PC and IF/ID write enables (= ~stall)
//   busy_mask               bit i set while register i has a pending load
//   stall_cycles            saturating stall-cycle counter
//   stall_err               sticky: MAX_STALL consecutive stall cycles seen
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW    = HS_REG_AW,
  parameter int LOAD_LAT  = HS_LOAD_LAT,
  parameter int ALU_FWD   = HS_ALU_FWD,
  parameter int BR_FWD    = HS_BR_FWD,
  parameter int R0_ZERO   = HS_R0_ZERO,
  parameter int MAX_STALL = HS_MAX_STALL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_is_branch,
  input  logic                   id_load,
  input  logic [REG_AW-1:0]      id_dst,
  input  logic                   id_flush,
  input  logic                   stat_clr,
  output logic                   ctrl_flush,
  output logic                   PCwrite,
  output logic                   Id_write,
  output logic [2**REG_AW-1:0]   busy_mask,
  output logic [15:0]            stall_cycles,
  output logic                   stall_err
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int CW       = cnt_width(LOAD_LAT);
  localparam int RW       = cnt_width(MAX_STALL);

  logic [CW-1:0] cnt [NUM_REGS];
  logic          stall;
  logic          issue;
  logic          hazard_rs;
  logic          hazard_rt;
  logic [31:0]   fwd_limit;

  logic [RW-1:0] run_reg, run_next;
  logic [15:0]   stall_cnt_reg, stall_cnt_next;
  logic          err_reg, err_next;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // Register 0 is hard-wired zero when R0_ZERO is set: never tracked.
      localparam bit IGNORE = (R0_ZERO != 0) && (gi == 0);
      logic load_en;

      assign load_en = !IGNORE && issue && (id_dst == REG_AW'(gi));

      hs_reg_counter #(
        .CW       (CW),
        .LOAD_VAL (LOAD_LAT)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_en),
        .count (cnt[gi])
      );

      assign busy_mask[gi] = (cnt[gi] != '0);
    end
  endgenerate

  // A source is safe once its remaining latency is within forwarding reach.
  always_comb begin
    fwd_limit = id_is_branch ? 32'(BR_FWD) : 32'(ALU_FWD);
    hazard_rs = id_use_rs && !((R0_ZERO != 0) && (id_rs == '0)) &&
                (32'(cnt[id_rs]) > fwd_limit);
    hazard_rt = id_use_rt && !((R0_ZERO != 0) && (id_rt == '0)) &&
                (32'(cnt[id_rt]) > fwd_limit);
    stall     = id_valid && !id_flush && (hazard_rs || hazard_rt);
    issue     = id_valid && id_load && !stall && !id_flush;
  end

  assign ctrl_flush = stall;
  assign PCwrite    = ~stall;
  assign Id_write   = ~stall;

  always_comb begin
    run_next       = '0;
    err_next       = err_reg;
    stall_cnt_next = stall_cnt_reg;
    if (stall) begin
      run_next = (32'(run_reg) < MAX_STALL) ? run_reg + 1'b1 : run_reg;
      if (32'(run_reg) + 1 >= MAX_STALL) begin
        err_next = 1'b1;
      end
      if (stall_cnt_reg != 16'hFFFF) begin
        stall_cnt_next = stall_cnt_reg + 16'd1;
      end
    end
    // Clear wins over a same-cycle increment.
    if (stat_clr) begin
      stall_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg       <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      run_reg       <= run_next;
      stall_cnt_reg <= stall_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign stall_err    = err_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int REG_AW    = 3;
  localparam int NREGS     = 8;
  localparam int LOAD_LAT  = 3;
  localparam int ALU_FWD   = 2;
  localparam int BR_FWD    = 0;
  localparam int MAX_STALL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  id_rs = '0;
  logic [2:0]  id_rt = '0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic        id_is_branch = 1'b0;
  logic        id_load = 1'b0;
  logic [2:0]  id_dst = '0;
  logic        id_flush = 1'b0;
  logic        stat_clr = 1'b0;
  logic        ctrl_flush;
  logic        PCwrite;
  logic        Id_write;
  logic [7:0]  busy_mask;
  logic [15:0] stall_cycles;
  logic        stall_err;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .REG_AW    (REG_AW),
    .LOAD_LAT  (LOAD_LAT),
    .ALU_FWD   (ALU_FWD),
    .BR_FWD    (BR_FWD),
    .R0_ZERO   (1),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_load      (id_load),
    .id_dst       (id_dst),
    .id_flush     (id_flush),
    .stat_clr     (stat_clr),
    .ctrl_flush   (ctrl_flush),
    .PCwrite      (PCwrite),
    .Id_write     (Id_write),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles),
    .stall_err    (stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: absolute cycle at which each register's load data is available.
  int ready_at [NREGS];
  int mcyc = 0;
  int m_run = 0;
  int m_sc = 0;
  bit m_err = 1'b0;

  function automatic int remaining(input int r);
    return (ready_at[r] > mcyc) ? ready_at[r] - mcyc : 0;
  endfunction

  always @(negedge clk) begin : model_cmp
    int   lim;
    bit   h_rs, h_rt, e_stall, e_issue;
    logic [7:0] e_busy;
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
      m_run = 0;
      m_sc  = 0;
      m_err = 1'b0;
      check("rst_ctrl_flush", 32'(ctrl_flush), 32'd0);
      check("rst_pcwrite", 32'(PCwrite), 32'd1);
      check("rst_busy", 32'(busy_mask), 32'd0);
      check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
      check("rst_stall_err", 32'(stall_err), 32'd0);
    end else begin
      lim     = id_is_branch ? BR_FWD : ALU_FWD;
      h_rs    = id_use_rs && (id_rs != 0) && (remaining(int'(id_rs)) > lim);
      h_rt    = id_use_rt && (id_rt != 0) && (remaining(int'(id_rt)) > lim);
      e_stall = id_valid && !id_flush && (h_rs || h_rt);
      e_issue = id_valid && id_load && !id_flush && !e_stall;
      for (int r = 0; r < NREGS; r++) e_busy[r] = (remaining(r) > 0);
      check("ctrl_flush", 32'(ctrl_flush), 32'(e_stall));
      check("PCwrite", 32'(PCwrite), 32'(!e_stall));
      check("Id_write", 32'(Id_write), 32'(!e_stall));
      check("busy_mask", 32'(busy_mask), 32'(e_busy));
      check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
      check("stall_err", 32'(stall_err), 32'(m_err));
      // Advance the model across the coming rising edge.
      if (e_issue && id_dst != 0) ready_at[id_dst] = mcyc + 1 + LOAD_LAT;
      if (stat_clr) m_sc = 0;
      else if (e_stall && m_sc < 65535) m_sc = m_sc + 1;
      if (e_stall) begin
        m_run = m_run + 1;
        if (m_run >= MAX_STALL) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    mcyc++;
  end

  task automatic drive(input bit v, input int rs, input int rt, input bit urs,
                       input bit urt, input bit br, input bit ld, input int dst,
                       input bit fl, input bit clr);
    id_valid = v;   id_rs = rs[2:0];  id_rt = rt[2:0];
    id_use_rs = urs; id_use_rt = urt; id_is_branch = br;
    id_load = ld;   id_dst = dst[2:0]; id_flush = fl; stat_clr = clr;
    $display("txn t=%0t v=%0b rs=%0d/%0b rt=%0d/%0b br=%0b ld=%0b dst=%0d fl=%0b clr=%0b",
             $time, v, rs, urs, rt, urt, br, ld, dst, fl, clr);
  endtask

  task automatic idle();              drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic load(input int d);   drive(1, 0, 0, 0, 0, 0, 1, d, 0, 0); endtask
  task automatic branch(input int s); drive(1, s, 0, 1, 0, 1, 0, 0, 0, 0); endtask
  task automatic tick();              @(posedge clk); #1; endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    #2;
    check("in_reset_flush", 32'(ctrl_flush), 32'd0);
    check("in_reset_pcwrite", 32'(PCwrite), 32'd1);
    check("in_reset_idwrite", 32'(Id_write), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    #2;
    check("post_reset_flush", 32'(ctrl_flush), 32'd0);
    check("post_reset_pcwrite", 32'(PCwrite), 32'd1);
    tick();

    // Load r3 then ALU use of r3: one stall cycle.
    load(3); tick();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    #2; check("alu_stall_flush", 32'(ctrl_flush), 32'd1);
    check("alu_stall_pc", 32'(PCwrite), 32'd0);
    tick();
    #2; check("alu_proceed", 32'(ctrl_flush), 32'd0);
    tick(); idle();
    #2; check("alu_sc", 32'(stall_cycles), 32'd1);
    check("alu_err", 32'(stall_err), 32'd0);
    repeat (3) tick();

    // Load r3 then branch on r3: three stall cycles, which also trips the watchdog.
    load(3); tick();
    branch(3);
    for (int k = 0; k < 3; k++) begin
      #2; check("br_stall", 32'(ctrl_flush), 32'd1);
      tick();
    end
    #2; check("br_proceed", 32'(ctrl_flush), 32'd0);
    tick(); idle();
    #2; check("br_sc", 32'(stall_cycles), 32'd4);
    check("br_err", 32'(stall_err), 32'd1);
    tick();
    reset_pulse();
    #2; check("err_cleared", 32'(stall_err), 32'd0);
    check("sc_cleared", 32'(stall_cycles), 32'd0);
    tick();

    // Load to r0 never hazards.
    load(0); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    #2; check("r0_flush", 32'(ctrl_flush), 32'd0);
    check("r0_busy", 32'(busy_mask), 32'd0);
    tick(); idle();

    // rs == rt: single hazard, one stall.
    load(6); tick();
    drive(1, 6, 6, 1, 1, 0, 0, 0, 0, 0);
    #2; check("same_src_stall", 32'(ctrl_flush), 32'd1);
    tick();
    #2; check("same_src_go", 32'(ctrl_flush), 32'd0);
    tick(); idle(); tick(); tick();

    // Flushed consumer (also a load to r4): no stall, no issue.
    load(3); tick();
    drive(1, 3, 0, 1, 0, 0, 1, 4, 1, 0);
    #2; check("flush_no_stall", 32'(ctrl_flush), 32'd0);
    check("flush_pcwrite", 32'(PCwrite), 32'd1);
    tick(); idle();
    #2; check("flush_no_issue", 32'(busy_mask), 32'h08);
    repeat (3) tick();

    // Back-to-back loads to r5, then branch on r5.
    load(5); tick();
    load(5); tick();
    branch(5);
    for (int k = 0; k < 3; k++) begin
      #2; check("b2b_stall", 32'(ctrl_flush), 32'd1);
      tick();
    end
    #2; check("b2b_proceed", 32'(ctrl_flush), 32'd0);
    tick(); idle();
    #2; check("b2b_err", 32'(stall_err), 32'd1);
    tick();
    reset_pulse();
    tick();

    // Isolated single stalls: run counter clears between them.
    load(3); tick();
    branch(3); tick();
    load(4); tick();
    branch(3); tick();
    idle(); tick();
    branch(4);
    #2; check("run_stall", 32'(ctrl_flush), 32'd1);
    tick(); idle();
    #2; check("run_no_err", 32'(stall_err), 32'd0);
    check("run_sc", 32'(stall_cycles), 32'd3);
    tick();

    // stat_clr during a stall.
    load(3); tick();
    branch(3); tick();
    drive(1, 3, 0, 1, 0, 1, 0, 0, 0, 1); tick();
    branch(3);
    #2; check("clr_wins", 32'(stall_cycles), 32'd0);
    tick(); idle();
    #2; check("clr_then_inc", 32'(stall_cycles), 32'd1);
    tick();
    reset_pulse();
    tick();

    // Reset mid-stall drops the stall at once.
    load(3); tick();
    branch(3);
    #2; check("pre_rst_stall", 32'(ctrl_flush), 32'd1);
    rst_n = 1'b0;
    #1; check("rst_drops_stall", 32'(ctrl_flush), 32'd0);
    check("rst_pcwrite_hi", 32'(PCwrite), 32'd1);
    check("rst_busy_zero", 32'(busy_mask), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    idle();
    #2; check("after_rst_flush", 32'(ctrl_flush), 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
